// File: rtl/dmem_responder.sv
// Data-memory responder: big-endian byte-lane RAM behind a request/ready handshake
// with programmable wait states, misalignment detection and a sticky error flag.
module dmem_responder #(
  parameter int ADDR_W      = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  input  logic [1:0]  dsize,
  input  logic        dsign,
  input  logic        err_clr,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        misalign,
  output logic        err_sticky
);

  localparam int         DEPTH     = 2 ** (ADDR_W - 2);
  localparam logic [2:0] WAIT_INIT = 3'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic              misalign_q, misalign_d;
  logic              err_q, err_d;

  logic              commit_s;
  logic              bad_s;
  logic              wr_en_s;
  logic [ADDR_W-3:0] idx_s;
  logic [1:0]        off_s;
  logic [3:0]        lane_we_s;
  logic [3:0][7:0]   lane_wd_s;
  logic [3:0][7:0]   lane_rd_s;
  logic [7:0]        byte_s;
  logic [15:0]       half_s;
  logic [31:0]       rd_ext_s;
  logic              unused_s;

  // Address bits above the RAM size simply wrap.
  assign unused_s = ^addr[31:ADDR_W];

  // Address split and alignment check
  always_comb begin
    idx_s = addr[ADDR_W-1:2];
    off_s = addr[1:0];
    case (dsize)
      2'b00:   bad_s = 1'b0;
      2'b01:   bad_s = addr[0];
      2'b10:   bad_s = (addr[1:0] != 2'b00);
      default: bad_s = 1'b1;
    endcase
  end

  // Lane write enables and data; lane 0 is the most significant byte (offset 0)
  always_comb begin
    wr_en_s = commit_s & we & ~bad_s & ~reset;
    for (int l = 0; l < 4; l++) begin
      case (dsize)
        2'b00: begin
          lane_we_s[l] = wr_en_s & (off_s == 2'(l));
          lane_wd_s[l] = wdata[7:0];
        end
        2'b01: begin
          lane_we_s[l] = wr_en_s & (off_s[1] == l[1]);
          lane_wd_s[l] = l[0] ? wdata[7:0] : wdata[15:8];
        end
        2'b10: begin
          lane_we_s[l] = wr_en_s;
          lane_wd_s[l] = wdata[31-8*l -: 8];
        end
        default: begin
          lane_we_s[l] = 1'b0;
          lane_wd_s[l] = 8'h00;
        end
      endcase
    end
  end

  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] mem [DEPTH];

    // Lane storage: no reset, contents survive a reset pulse
    always_ff @(posedge clk) begin
      if (lane_we_s[l]) begin
        mem[idx_s] <= lane_wd_s[l];
      end
    end

    assign lane_rd_s[l] = mem[idx_s];
  end

  // Read data selection and sign/zero extension
  always_comb begin
    byte_s = lane_rd_s[off_s];
    if (off_s[1]) begin
      half_s = {lane_rd_s[2], lane_rd_s[3]};
    end else begin
      half_s = {lane_rd_s[0], lane_rd_s[1]};
    end
    case (dsize)
      2'b00:   rd_ext_s = {{24{dsign & byte_s[7]}}, byte_s};
      2'b01:   rd_ext_s = {{16{dsign & half_s[15]}}, half_s};
      2'b10:   rd_ext_s = {lane_rd_s[0], lane_rd_s[1], lane_rd_s[2], lane_rd_s[3]};
      default: rd_ext_s = 32'h0000_0000;
    endcase
  end

  // Next-state logic for the request FSM and its registered outputs
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    ready_d    = ready_q;
    misalign_d = misalign_q;
    commit_s   = 1'b0;
    if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (we | re) begin
          if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
          end else begin
            commit_s = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q <= 3'd1) begin
          commit_s = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_RESP: begin
        state_d    = ST_IDLE;
        ready_d    = 1'b0;
        misalign_d = 1'b0;
        rdata_d    = 32'h0000_0000;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 3'd0;
      end
    endcase

    // A new error on the commit edge overrides a simultaneous clear.
    if (commit_s) begin
      state_d    = ST_RESP;
      cnt_d      = 3'd0;
      ready_d    = 1'b1;
      misalign_d = bad_s;
      if (bad_s || we) begin
        rdata_d = 32'h0000_0000;
      end else begin
        rdata_d = rd_ext_s;
      end
      if (bad_s) begin
        err_d = 1'b1;
      end else begin
        err_d = err_d;
      end
    end else begin
      commit_s = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 3'd0;
      rdata_q    <= 32'h0000_0000;
      ready_q    <= 1'b0;
      misalign_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      ready_q    <= ready_d;
      misalign_q <= misalign_d;
      err_q      <= err_d;
    end
  end

  assign rdata      = rdata_q;
  assign ready      = ready_q;
  assign misalign   = misalign_q;
  assign err_sticky = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, byte-array reference model with
// random traffic, plus wait-state timing, reset-abort and aliasing sequences.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] t_addr [2];
  logic [31:0] t_wdata [2];
  logic [31:0] t_rdata [2];
  logic        t_we [2];
  logic        t_re [2];
  logic        t_dsign [2];
  logic        t_clr [2];
  logic        t_ready [2];
  logic        t_mis [2];
  logic        t_err [2];
  logic [1:0]  t_dsize [2];

  int n_vec = 0;
  int n_mis = 0;

  // Reference: plain byte memory per DUT plus sticky flag
  logic [7:0] mdl [2][4096];
  bit         msticky [2];

  typedef struct {
    bit          we;
    bit          re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  dsize;
    bit          dsign;
    logic [31:0] exp_rd;
    bit          exp_mis;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(12), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(reset), .addr(t_addr[0]), .wdata(t_wdata[0]),
    .we(t_we[0]), .re(t_re[0]), .dsize(t_dsize[0]), .dsign(t_dsign[0]),
    .err_clr(t_clr[0]), .rdata(t_rdata[0]), .ready(t_ready[0]),
    .misalign(t_mis[0]), .err_sticky(t_err[0])
  );

  dmem_responder #(.ADDR_W(12), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .reset(reset), .addr(t_addr[1]), .wdata(t_wdata[1]),
    .we(t_we[1]), .re(t_re[1]), .dsize(t_dsize[1]), .dsign(t_dsign[1]),
    .err_clr(t_clr[1]), .rdata(t_rdata[1]), .ready(t_ready[1]),
    .misalign(t_mis[1]), .err_sticky(t_err[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_access(input int d, input bit w, input bit r, input logic [31:0] a,
                              input logic [31:0] wd, input logic [1:0] sz, input bit sg,
                              output logic [31:0] rd, output bit mis);
    int          base;
    int          n;
    logic [31:0] v;
    base = int'(a[11:0]);
    n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    mis  = (sz == 2'd3) || ((base % n) != 0);
    rd   = 32'h0;
    v    = 32'h0;
    if (mis) begin
      msticky[d] = 1'b1;
    end else if (w) begin
      for (int i = 0; i < n; i++) mdl[d][base+i] = wd[8*(n-1-i) +: 8];
    end else if (r) begin
      for (int i = 0; i < n; i++) v = (v << 8) | 32'(mdl[d][base+i]);
      if (n < 4 && sg && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      rd = v;
    end
  endtask

  task automatic run_req(input int d, input bit w, input bit r, input logic [31:0] a,
                         input logic [31:0] wd, input logic [1:0] sz, input bit sg,
                         input bit clr, input string nm,
                         output logic [31:0] rd, output bit mis, output bit err);
    int cyc;
    bit got;
    t_addr[d]  = a;
    t_wdata[d] = wd;
    t_dsize[d] = sz;
    t_dsign[d] = sg;
    t_we[d]    = w;
    t_re[d]    = r;
    t_clr[d]   = clr;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (t_ready[d]) got = 1'b1;
    end
    rd  = t_rdata[d];
    mis = t_mis[d];
    err = t_err[d];
    t_we[d]  = 1'b0;
    t_re[d]  = 1'b0;
    t_clr[d] = 1'b0;
    chk({nm, " timeout"}, 32'(got), 32'd1);
    chk({nm, " latency"}, 32'(cyc), (d == 0) ? 32'd1 : 32'd4);
    @(posedge clk);
    #1;
    chk({nm, " ready/misalign drop"}, {30'd0, t_ready[d], t_mis[d]}, 32'd0);
    chk({nm, " rdata drop"}, t_rdata[d], 32'd0);
  endtask

  task automatic xact_model(input int d, input bit w, input bit r, input logic [31:0] a,
                            input logic [31:0] wd, input logic [1:0] sz, input bit sg,
                            input bit clr, input string nm);
    logic [31:0] exp_rd, got_rd;
    bit          exp_mis, got_mis, got_err;
    if (clr) msticky[d] = 1'b0;
    model_access(d, w, r, a, wd, sz, sg, exp_rd, exp_mis);
    run_req(d, w, r, a, wd, sz, sg, clr, nm, got_rd, got_mis, got_err);
    chk({nm, " rdata"}, got_rd, exp_rd);
    chk({nm, " misalign"}, 32'(got_mis), 32'(exp_mis));
    chk({nm, " err_sticky"}, 32'(got_err), 32'(msticky[d]));
  endtask

  initial begin
    logic [31:0] rd, exp_rd, a, low;
    bit          mis, err, exp_mis, w, r;
    logic [1:0]  sz;
    int          op, n;

    for (int d = 0; d < 2; d++) begin
      t_addr[d] = 32'h0; t_wdata[d] = 32'h0; t_we[d] = 1'b0; t_re[d] = 1'b0;
      t_dsize[d] = 2'd0; t_dsign[d] = 1'b0; t_clr[d] = 1'b0; msticky[d] = 1'b0;
    end

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset rdata", t_rdata[d], 32'd0);
      chk("reset ready", 32'(t_ready[d]), 32'd0);
      chk("reset misalign", 32'(t_mis[d]), 32'd0);
      chk("reset err_sticky", 32'(t_err[d]), 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    //            we    re    addr            wdata           sz     sg    exp_rd          mis
    tbl.push_back('{1'b1, 1'b0, 32'h0000_0010, 32'h1234_5678, 2'd2, 1'b0, 32'h0000_0000, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 32'h0000_0010, 32'h0,         2'd0, 1'b0, 32'h0000_0012, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 32'h0000_0011, 32'h0,         2'd0, 1'b0, 32'h0000_0034, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 32'h0000_0012, 32'h0,         2'd0, 1'b0, 32'h0000_0056, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 32'h0000_0013, 32'h0,         2'd0, 1'b0, 32'h0000_0078, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 32'h0000_0012, 32'h0,         2'd1, 1'b0, 32'h0000_5678, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 32'h0000_0012, 32'h0,         2'd1, 1'b1, 32'h0000_5678, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 32'h0000_0005, 32'h0000_0080, 2'd0, 1'b0, 32'h0000_0000, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 32'h0000_0005, 32'h0,         2'd0, 1'b1, 32'hFFFF_FF80, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 32'h0000_0005, 32'h0,         2'd0, 1'b0, 32'h0000_0080, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 32'h0000_0004, 32'h0000_007F, 2'd0, 1'b0, 32'h0000_0000, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 32'h0000_0004, 32'h0,         2'd1, 1'b1, 32'h0000_7F80, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 32'h0000_0020, 32'hAAAA_AAAA, 2'd2, 1'b0, 32'h0000_0000, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 32'h0000_0022, 32'h0000_BEEF, 2'd1, 1'b0, 32'h0000_0000, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 32'h0000_0020, 32'h0,         2'd2, 1'b0, 32'hAAAA_BEEF, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 32'h0000_0022, 32'h0,         2'd1, 1'b1, 32'hFFFF_BEEF, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 32'h0000_0020, 32'h0,         2'd2, 1'b1, 32'hAAAA_BEEF, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 32'h0000_0000, 32'h1122_3344, 2'd2, 1'b0, 32'h0000_0000, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 32'h0000_0002, 32'hDEAD_BEEF, 2'd2, 1'b0, 32'h0000_0000, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 32'h0000_0000, 32'h0,         2'd2, 1'b0, 32'h1122_3344, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 32'h0000_0001, 32'h0,         2'd1, 1'b0, 32'h0000_0000, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 32'h0000_0000, 32'h0,         2'd3, 1'b0, 32'h0000_0000, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 32'h0000_0030, 32'hCAFE_F00D, 2'd2, 1'b0, 32'h0000_0000, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 32'h0000_0030, 32'h0,         2'd2, 1'b0, 32'hCAFE_F00D, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 32'h0000_0033, 32'h0000_1234, 2'd1, 1'b0, 32'h0000_0000, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 32'h0000_0030, 32'h0,         2'd2, 1'b0, 32'hCAFE_F00D, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 32'h0000_1010, 32'h0BAD_CAFE, 2'd2, 1'b0, 32'h0000_0000, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 32'h0000_0010, 32'h0,         2'd2, 1'b0, 32'h0BAD_CAFE, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 32'hFFFF_F013, 32'h0,         2'd0, 1'b0, 32'h0000_00FE, 1'b0});

    foreach (tbl[i]) begin
      model_access(0, tbl[i].we, tbl[i].re, tbl[i].addr, tbl[i].wdata, tbl[i].dsize,
                   tbl[i].dsign, exp_rd, exp_mis);
      run_req(0, tbl[i].we, tbl[i].re, tbl[i].addr, tbl[i].wdata, tbl[i].dsize,
              tbl[i].dsign, 1'b0, $sformatf("vec%0d", i), rd, mis, err);
      chk($sformatf("vec%0d rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("vec%0d misalign", i), 32'(mis), 32'(tbl[i].exp_mis));
      chk($sformatf("vec%0d err_sticky", i), 32'(err), 32'(msticky[0]));
    end

    // err_clr pulse clears the sticky flag
    chk("sticky before clr", 32'(t_err[0]), 32'd1);
    t_clr[0] = 1'b1;
    @(posedge clk);
    #1;
    t_clr[0] = 1'b0;
    msticky[0] = 1'b0;
    chk("sticky after clr", 32'(t_err[0]), 32'd0);

    // clear held across an erroring commit: set wins; across a clean one: cleared
    xact_model(0, 1'b0, 1'b1, 32'h0000_0006, 32'h0, 2'd2, 1'b0, 1'b1, "clr+err");
    xact_model(0, 1'b0, 1'b1, 32'h0000_0004, 32'h0, 2'd2, 1'b0, 1'b1, "clr+ok");

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 64; i++)
        xact_model(d, 1'b1, 1'b0, 32'(i * 4), $urandom, 2'd2, 1'b0, 1'b0, "preload");

    for (int k = 0; k < 160; k++) begin
      op  = $urandom_range(0, 3);
      w   = (op == 1) || (op == 2);
      r   = (op != 1);
      sz  = 2'($urandom_range(0, 3));
      n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      low = 32'($urandom_range(0, 255));
      if (sz != 2'd3 && $urandom_range(0, 3) != 0) low = low & ~(32'(n) - 32'd1);
      a   = ($urandom & 32'hFFFF_F000) | low;
      xact_model(k % 2, w, r, a, $urandom, sz, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0), $sformatf("rnd%0d", k));
    end

    // Three wait states, request held: ready only in cycles 4 and 9
    model_access(1, 1'b0, 1'b1, 32'h0000_0040, 32'h0, 2'd2, 1'b0, exp_rd, exp_mis);
    t_addr[1] = 32'h0000_0040; t_dsize[1] = 2'd2; t_dsign[1] = 1'b0; t_re[1] = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("b2b ready c%0d", c), 32'(t_ready[1]), 32'((c == 4) || (c == 9)));
      if (c == 4) chk("b2b rdata", t_rdata[1], exp_rd);
      if (c == 9) t_re[1] = 1'b0;
    end

    // Reset during the wait of a write aborts it
    t_addr[1] = 32'h0000_0010; t_wdata[1] = 32'h5A5A_5A5A; t_dsize[1] = 2'd2; t_we[1] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("mid reset ready", 32'(t_ready[d]), 32'd0);
      chk("mid reset rdata", t_rdata[d], 32'd0);
      chk("mid reset misalign", 32'(t_mis[d]), 32'd0);
      chk("mid reset err_sticky", 32'(t_err[d]), 32'd0);
      msticky[d] = 1'b0;
    end
    t_we[1] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    xact_model(1, 1'b0, 1'b1, 32'h0000_0010, 32'h0, 2'd2, 1'b0, 1'b0, "post reset read");
    xact_model(0, 1'b0, 1'b1, 32'h0000_0010, 32'h0, 2'd2, 1'b0, 1'b0, "dut0 kept data");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
